// File: rtl/cp0_exception_sequencer_if.sv
// Fetch redirect handshake between the exception sequencer and fetch.
// master drives the target; slave accepts it with ready.
interface cp0_exception_sequencer_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/cp0_exception_sequencer.sv
// Picks one exception/interrupt, drains memory, pulses CP0, redirects fetch.
// Define CP0_EXC_PERF_EN to build the committed exception/interrupt counters.
module cp0_exception_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int CAUSE_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*CAUSE_W-1:0] src_cause,
  input  logic [NUM_SRC*32-1:0]      src_pc,
  input  logic [NUM_SRC*32-1:0]      src_badvaddr,
  input  logic [NUM_SRC-1:0]         src_bd,
  input  logic                       int_req,
  input  logic                       commit_valid,
  input  logic [31:0]                commit_pc,
  input  logic                       commit_bd,
  input  logic                       mem_busy,
  input  logic                       cp0_jump,
  input  logic [31:0]                cp0_jump_addr,
  output logic                       exc_in_pipe,
  output logic                       cp0_exc,
  output logic [CAUSE_W-1:0]         cp0_cause,
  output logic [31:0]                cp0_pc,
  output logic [31:0]                cp0_badvaddr,
  output logic                       cp0_bd,
  output logic                       flush,
  cp0_exception_sequencer_if.master  redir,
  output logic [31:0]                perf_exc_cnt,
  output logic [31:0]                perf_int_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT
  } state_t;

  state_t state;

  logic               winValid;
  logic [CAUSE_W-1:0] winCause;
  logic [31:0]        winPc;
  logic [31:0]        winBad;
  logic               winBd;

  logic [CAUSE_W-1:0] capCause;
  logic [31:0]        capPc;
  logic [31:0]        capBad;
  logic               capBd;

  logic               rdValid;
  logic [31:0]        rdPc;

  // Scan from youngest to oldest so the oldest valid source wins;
  // an interrupt on a real instruction overrides every stage.
  always_comb begin
    winValid = 1'b0;
    winCause = '0;
    winPc    = '0;
    winBad   = '0;
    winBd    = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        winValid = 1'b1;
        winCause = src_cause[i*CAUSE_W +: CAUSE_W];
        winPc    = src_pc[i*32 +: 32];
        winBad   = src_badvaddr[i*32 +: 32];
        winBd    = src_bd[i];
      end
    end
    if (int_req && commit_valid) begin
      winValid = 1'b1;
      winCause = '0;
      winPc    = commit_pc;
      winBad   = '0;
      winBd    = commit_bd;
    end
  end

  assign exc_in_pipe = (state != IDLE) | (|src_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      capCause     <= '0;
      capPc        <= '0;
      capBad       <= '0;
      capBd        <= 1'b0;
      cp0_exc      <= 1'b0;
      cp0_cause    <= '0;
      cp0_pc       <= '0;
      cp0_badvaddr <= '0;
      cp0_bd       <= 1'b0;
      flush        <= 1'b0;
      rdValid      <= 1'b0;
      rdPc         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (winValid) begin
            state    <= DRAIN;
            flush    <= 1'b1;
            capCause <= winCause;
            capPc    <= winPc;
            capBad   <= winBad;
            capBd    <= winBd;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            state        <= COMMIT;
            cp0_exc      <= 1'b1;
            cp0_cause    <= capCause;
            cp0_pc       <= capPc;
            cp0_badvaddr <= capBad;
            cp0_bd       <= capBd;
          end
        end
        COMMIT: begin
          state        <= REDIRECT;
          cp0_exc      <= 1'b0;
          cp0_cause    <= '0;
          cp0_pc       <= '0;
          cp0_badvaddr <= '0;
          cp0_bd       <= 1'b0;
          rdValid      <= 1'b1;
          // CP0 missing a jump is a protocol error; fall back to the faulting PC.
          rdPc         <= cp0_jump ? cp0_jump_addr : capPc;
        end
        REDIRECT: begin
          if (redir.redirect_ready) begin
            state   <= IDLE;
            flush   <= 1'b0;
            rdValid <= 1'b0;
            rdPc    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign redir.redirect_valid = rdValid;
  assign redir.redirect_pc    = rdPc;

`ifdef CP0_EXC_PERF_EN
  logic [31:0] excCnt;
  logic [31:0] intCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      excCnt <= '0;
      intCnt <= '0;
    end else if (state == COMMIT) begin
      if (capCause != '0) begin
        excCnt <= excCnt + 32'd1;
      end else begin
        intCnt <= intCnt + 32'd1;
      end
    end
  end

  assign perf_exc_cnt = excCnt;
  assign perf_int_cnt = intCnt;
`else
  assign perf_exc_cnt = '0;
  assign perf_int_cnt = '0;
`endif

endmodule
